alu_arbiter: RTL and testbench

Two-port arbiter and sequencer that shares the single combinational `alu` between the execute stage (port 0) and the branch/address unit (port 1). It accepts one operation per requester, drives the ALU operands, opcode and flag-update enable for exactly one cycle, and returns the captured result and flags through a per-port one-entry response buffer. Port 0 has fixed priority, and a starvation counter bounds how long port 1 can wait.

---
 rtl/alu_arbiter_pkg.sv | 33 +++
 rtl/alu_rsp_buf.sv | 31 +++
 rtl/alu_arbiter.sv | 149 ++++++++++++++
 tb/tb_alu_arbiter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared ALU definitions: opcodes, flag bit positions and the arbiter FSM states.
// Common with the alu and the instruction decoder.
package alu_arbiter_pkg;

  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;
  localparam logic [2:0] OP_NOT = 3'd6;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } arb_state_t;

  function automatic logic [3:0] pack_flags(input logic n, input logic z,
                                            input logic c, input logic v);
    logic [3:0] f;
    f         = '0;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/alu_rsp_buf.sv
// One-entry result/flag buffer; written one cycle after the ALU is driven, zero-latency drain.
// Backpressure: stays full until rsp_ready; a same-cycle write wins over the drain.
module alu_rsp_buf #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_result,
  input  logic [3:0]       wr_flags,
  input  logic             rsp_ready,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_result,
  output logic [3:0]       rsp_flags
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_flags  <= '0;
    end else if (wr_en) begin
      rsp_valid  <= 1'b1;
      rsp_result <= wr_result;
      rsp_flags  <= wr_flags;
    end else if (rsp_ready) begin
      rsp_valid  <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters: grant N, ALU driven N+1, response valid N+2.
// Backpressure: a port whose response buffer is full and not draining is skipped in arbitration.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,

  input  logic             r0_req,
  input  logic [2:0]       r0_op,
  input  logic [WIDTH-1:0] r0_a,
  input  logic [WIDTH-1:0] r0_b,
  input  logic             r0_setflags,
  output logic             r0_gnt,
  output logic             r0_rsp_valid,
  input  logic             r0_rsp_ready,
  output logic [WIDTH-1:0] r0_rsp_result,
  output logic [3:0]       r0_rsp_flags,

  input  logic             r1_req,
  input  logic [2:0]       r1_op,
  input  logic [WIDTH-1:0] r1_a,
  input  logic [WIDTH-1:0] r1_b,
  input  logic             r1_setflags,
  output logic             r1_gnt,
  output logic             r1_rsp_valid,
  input  logic             r1_rsp_ready,
  output logic [WIDTH-1:0] r1_rsp_result,
  output logic [3:0]       r1_rsp_flags,

  output logic [WIDTH-1:0] alu_op1,
  output logic [WIDTH-1:0] alu_op2,
  output logic [2:0]       alu_instr,
  output logic             alu_flag_en,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  input  logic             alu_carry,
  input  logic             alu_overflow,
  input  logic             alu_negative
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  arb_state_t       state_q, state_d;
  logic [3:0]       starve_cnt;
  logic [2:0]       lat_op;
  logic [WIDTH-1:0] lat_a, lat_b;
  logic             lat_setflags;
  logic             lat_owner;
  logic             elig0, elig1;
  logic             grant0, grant1;
  logic             wr0, wr1;
  logic [3:0]       alu_flags;

  // A full buffer that drains this cycle can accept the next operation.
  assign elig0 = r0_req & (~r0_rsp_valid | r0_rsp_ready);
  assign elig1 = r1_req & (~r1_rsp_valid | r1_rsp_ready);

  always_comb begin
    state_d     = state_q;
    grant0      = 1'b0;
    grant1      = 1'b0;
    alu_op1     = '0;
    alu_op2     = '0;
    alu_instr   = '0;
    alu_flag_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rst_n) begin
          if (starve_cnt == LIMIT && elig1) grant1 = 1'b1;
          else if (elig0)                   grant0 = 1'b1;
          else if (elig1)                   grant1 = 1'b1;
        end
        if (grant0 || grant1) state_d = ST_EXEC;
      end
      ST_EXEC: begin
        // Holding outputs at zero under reset keeps a discarded op from touching the flags.
        if (rst_n) begin
          alu_op1     = lat_a;
          alu_op2     = lat_b;
          alu_instr   = lat_op;
          alu_flag_en = lat_setflags;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign r0_gnt = grant0;
  assign r1_gnt = grant1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      starve_cnt   <= '0;
      lat_op       <= '0;
      lat_a        <= '0;
      lat_b        <= '0;
      lat_setflags <= 1'b0;
      lat_owner    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant0 || grant1) begin
        lat_op       <= grant1 ? r1_op       : r0_op;
        lat_a        <= grant1 ? r1_a        : r0_a;
        lat_b        <= grant1 ? r1_b        : r0_b;
        lat_setflags <= grant1 ? r1_setflags : r0_setflags;
        lat_owner    <= grant1;
      end
      if (grant1)
        starve_cnt <= '0;
      else if (grant0 && elig1 && starve_cnt != LIMIT)
        starve_cnt <= starve_cnt + 4'd1;
    end
  end

  assign alu_flags = pack_flags(alu_negative, alu_zero, alu_carry, alu_overflow);
  assign wr0       = (state_q == ST_EXEC) && !lat_owner;
  assign wr1       = (state_q == ST_EXEC) &&  lat_owner;

  alu_rsp_buf #(.WIDTH(WIDTH)) u_buf0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr0),
    .wr_result  (alu_result),
    .wr_flags   (alu_flags),
    .rsp_ready  (r0_rsp_ready),
    .rsp_valid  (r0_rsp_valid),
    .rsp_result (r0_rsp_result),
    .rsp_flags  (r0_rsp_flags)
  );

  alu_rsp_buf #(.WIDTH(WIDTH)) u_buf1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr1),
    .wr_result  (alu_result),
    .wr_flags   (alu_flags),
    .rsp_ready  (r1_rsp_ready),
    .rsp_valid  (r1_rsp_valid),
    .rsp_result (r1_rsp_result),
    .rsp_flags  (r1_rsp_flags)
  );

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU with flag registers, directed scenarios, then random traffic.
module tb_alu_arbiter;

  localparam int STARVE = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_d[2];
  logic [2:0]  op_d[2];
  logic [31:0] a_d[2];
  logic [31:0] b_d[2];
  logic        sf_d[2];
  logic        rdy_d[2];

  logic        r0_gnt, r1_gnt, r0_rsp_valid, r1_rsp_valid;
  logic [31:0] r0_rsp_result, r1_rsp_result;
  logic [3:0]  r0_rsp_flags, r1_rsp_flags;
  logic [31:0] alu_op1, alu_op2, alu_result;
  logic [2:0]  alu_instr;
  logic        alu_flag_en, alu_zero, alu_carry, alu_overflow, alu_negative;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(32), .STARVE_LIMIT(STARVE)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_req(req_d[0]), .r0_op(op_d[0]), .r0_a(a_d[0]), .r0_b(b_d[0]), .r0_setflags(sf_d[0]),
    .r0_gnt(r0_gnt), .r0_rsp_valid(r0_rsp_valid), .r0_rsp_ready(rdy_d[0]),
    .r0_rsp_result(r0_rsp_result), .r0_rsp_flags(r0_rsp_flags),
    .r1_req(req_d[1]), .r1_op(op_d[1]), .r1_a(a_d[1]), .r1_b(b_d[1]), .r1_setflags(sf_d[1]),
    .r1_gnt(r1_gnt), .r1_rsp_valid(r1_rsp_valid), .r1_rsp_ready(rdy_d[1]),
    .r1_rsp_result(r1_rsp_result), .r1_rsp_flags(r1_rsp_flags),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_instr(alu_instr), .alu_flag_en(alu_flag_en),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_carry(alu_carry),
    .alu_overflow(alu_overflow), .alu_negative(alu_negative)
  );

  // Behavioural ALU: {N,Z,C,V,result}; C on SUB means "no borrow".
  function automatic logic [35:0] alu_eval(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    logic [32:0] s;
    logic [31:0] r;
    logic        c, v;
    s = '0; r = '0; c = 1'b0; v = 1'b0;
    case (op)
      3'd1: begin s = {1'b0, a} + {1'b0, b}; r = s[31:0]; c = s[32];
                  v = (a[31] == b[31]) && (r[31] != a[31]); end
      3'd2: begin r = a - b; c = (a >= b); v = (a[31] != b[31]) && (r[31] != a[31]); end
      3'd3: r = a & b;
      3'd4: r = a | b;
      3'd5: r = a ^ b;
      3'd6: r = ~a;
      default: r = '0;
    endcase
    return {r[31], (r == 32'd0), c, v, r};
  endfunction

  logic [3:0]  alu_fl_q = 4'd0;
  logic [35:0] alu_calc;
  logic [3:0]  alu_fl_out;
  assign alu_calc     = alu_eval(alu_instr, alu_op1, alu_op2);
  assign alu_result   = alu_calc[31:0];
  assign alu_fl_out   = alu_flag_en ? alu_calc[35:32] : alu_fl_q;
  assign alu_negative = alu_fl_out[3];
  assign alu_zero     = alu_fl_out[2];
  assign alu_carry    = alu_fl_out[1];
  assign alu_overflow = alu_fl_out[0];
  always @(posedge clk) if (alu_flag_en) alu_fl_q <= alu_calc[35:32];

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: what the arbiter has promised, in transaction terms.
  logic        m_busy;        // an accepted op is on the ALU this cycle
  int          m_owner;
  logic [2:0]  m_op;
  logic [31:0] m_a, m_b;
  logic        m_sf;
  int          m_starve;
  logic        m_valid[2];
  logic [31:0] m_res[2];
  logic [3:0]  m_flg[2];
  logic [3:0]  m_arch = 4'd0;
  int          obs_g;         // port the DUT granted in the last cycle, -1 for none
  logic        obs_fe;

  task automatic model_reset();
    m_busy = 1'b0; m_starve = 0; m_owner = 0;
    for (int p = 0; p < 2; p++) begin m_valid[p] = 1'b0; m_res[p] = '0; m_flg[p] = '0; end
  endtask

  // Called at a falling edge with inputs already applied; returns at the next falling edge.
  task automatic tick();
    int g;
    logic e[2];
    logic [35:0] c;
    #1;
    g = -1; e[0] = 1'b0; e[1] = 1'b0; c = '0;
    if (rst_n && !m_busy) begin
      for (int p = 0; p < 2; p++) e[p] = req_d[p] && (!m_valid[p] || rdy_d[p]);
      if (m_starve == STARVE && e[1]) g = 1;
      else if (e[0]) g = 0;
      else if (e[1]) g = 1;
    end
    obs_g  = r0_gnt ? 0 : (r1_gnt ? 1 : -1);
    obs_fe = alu_flag_en;
    check("gnt0", r0_gnt, g == 0);
    check("gnt1", r1_gnt, g == 1);
    check("vld0", r0_rsp_valid, m_valid[0]);
    check("vld1", r1_rsp_valid, m_valid[1]);
    if (m_valid[0]) begin check("res0", r0_rsp_result, m_res[0]); check("flg0", r0_rsp_flags, m_flg[0]); end
    if (m_valid[1]) begin check("res1", r1_rsp_result, m_res[1]); check("flg1", r1_rsp_flags, m_flg[1]); end
    check("flag_en", alu_flag_en, rst_n && m_busy && m_sf);
    check("instr", alu_instr, (rst_n && m_busy) ? m_op : 3'd0);
    check("op1", alu_op1, (rst_n && m_busy) ? m_a : 32'd0);
    check("op2", alu_op2, (rst_n && m_busy) ? m_b : 32'd0);
    check("arch_flags", alu_fl_q, m_arch);
    if (!rst_n) model_reset();
    else begin
      if (m_busy) c = alu_eval(m_op, m_a, m_b);
      for (int p = 0; p < 2; p++) begin
        if (m_busy && m_owner == p) begin
          m_valid[p] = 1'b1; m_res[p] = c[31:0];
          m_flg[p]   = m_sf ? c[35:32] : m_arch;
        end else if (rdy_d[p]) m_valid[p] = 1'b0;
      end
      if (m_busy && m_sf) m_arch = c[35:32];
      if (g == 1) m_starve = 0;
      else if (g == 0 && e[1] && m_starve < STARVE) m_starve++;
      m_busy = (g >= 0);
      if (g >= 0) begin
        m_owner = g; m_op = op_d[g]; m_a = a_d[g]; m_b = b_d[g]; m_sf = sf_d[g];
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input int p, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic sf);
    req_d[p] = 1'b1; op_d[p] = op; a_d[p] = a; b_d[p] = b; sf_d[p] = sf;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  int          order_q[$];
  int          exp_order[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
  logic [3:0]  arch_save;
  logic        pend[2];

  initial begin
    rst_n = 1'b0;
    for (int p = 0; p < 2; p++) begin
      req_d[p] = 1'b0; op_d[p] = '0; a_d[p] = '0; b_d[p] = '0; sf_d[p] = 1'b0; rdy_d[p] = 1'b0;
      pend[p] = 1'b0;
    end
    model_reset();
    @(negedge clk);
    do_reset();
    check("rst_res0", r0_rsp_result, 32'd0);
    check("rst_flg1", r1_rsp_flags, 4'd0);

    // Single ADD with overflow on port 0
    drive(0, 3'd1, 32'h7FFF_FFFF, 32'd1, 1'b1);
    tick(); check("add_gnt", obs_g, 0); check("add_fe_c0", obs_fe, 1'b0);
    req_d[0] = 1'b0;
    tick(); check("add_fe_c1", obs_fe, 1'b1);
    tick(); check("add_fe_c2", obs_fe, 1'b0);
    check("add_res", r0_rsp_result, 32'h8000_0000);
    check("add_flg", r0_rsp_flags, 4'b1001);
    rdy_d[0] = 1'b1; rdy_d[1] = 1'b1;

    // Clear flags, then SUB 5-5 without flag update on port 1
    drive(1, 3'd3, 32'd1, 32'd1, 1'b1);
    tick(); req_d[1] = 1'b0; tick(); tick();
    drive(1, 3'd2, 32'd5, 32'd5, 1'b0);
    rdy_d[1] = 1'b0;
    tick(); check("sub_gnt", obs_g, 1); check("sub_fe0", obs_fe, 1'b0);
    req_d[1] = 1'b0;
    tick(); check("sub_fe1", obs_fe, 1'b0);
    tick();
    check("sub_res", r1_rsp_result, 32'd0);
    check("sub_flg", r1_rsp_flags, 4'b0000);
    rdy_d[1] = 1'b1;

    // Both ports requesting continuously: starvation ordering
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(0, 3'($urandom_range(1, 6)), $urandom, $urandom, 1'($urandom));
      drive(1, 3'($urandom_range(1, 6)), $urandom, $urandom, 1'($urandom));
      tick();
      if (obs_g >= 0) order_q.push_back(obs_g);
    end
    req_d[0] = 1'b0; req_d[1] = 1'b0;
    check("order_len", order_q.size(), 10);
    for (int i = 0; i < 10 && i < order_q.size(); i++) check("order", order_q[i], exp_order[i]);
    tick();

    // Backpressure on port 0
    do_reset();
    rdy_d[0] = 1'b0;
    drive(0, 3'd1, 32'd1, 32'd2, 1'b0);
    tick(); req_d[0] = 1'b0; tick();
    drive(0, 3'd4, 32'd3, 32'd4, 1'b0);
    drive(1, 3'd5, 32'd6, 32'd5, 1'b0);
    tick(); check("bp_skip", obs_g, 1);
    req_d[1] = 1'b0;
    tick();
    tick(); check("bp_blocked", obs_g, -1);
    rdy_d[0] = 1'b1;
    tick(); check("bp_regrant", obs_g, 0);
    req_d[0] = 1'b0;
    tick(); tick();

    // Reset while an op is executing
    drive(0, 3'd1, 32'hFFFF_FFFF, 32'd1, 1'b1);
    arch_save = m_arch;
    tick(); req_d[0] = 1'b0;
    rst_n = 1'b0;
    tick(); check("rme_fe", obs_fe, 1'b0);
    rst_n = 1'b1;
    tick();
    check("rme_vld", r0_rsp_valid, 1'b0);
    check("rme_flags", alu_fl_q, arch_save);

    // Opcode 7
    rdy_d[0] = 1'b0;
    drive(0, 3'd7, 32'd123, 32'd456, 1'b1);
    tick(); req_d[0] = 1'b0; tick(); tick();
    check("op7_vld", r0_rsp_valid, 1'b1);
    check("op7_res", r0_rsp_result, 32'd0);
    check("op7_z", r0_rsp_flags[2], 1'b1);
    rdy_d[0] = 1'b1;
    tick();

    // Random traffic with random backpressure and occasional reset
    for (int i = 0; i < 800; i++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && $urandom_range(0, 2) == 0) begin
          pend[p] = 1'b1;
          drive(p, 3'($urandom_range(0, 7)),
                ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF : $urandom,
                ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom, 1'($urandom));
        end
        req_d[p] = pend[p];
        rdy_d[p] = ($urandom_range(0, 3) != 0);
      end
      rst_n = ($urandom_range(0, 99) != 0);
      tick();
      if (rst_n && obs_g >= 0) pend[obs_g] = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
